// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT twiddle-select constants, sequencer state type and sat16 helper
package fft_pkg;

  localparam logic [1:0]  TW_W0          = 2'd0;
  localparam logic [1:0]  TW_W8_1        = 2'd1;
  localparam logic [1:0]  TW_W8_2        = 2'd2;
  localparam logic [11:0] HALF_SQRT2_Q12 = 12'd2896;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL_S = 2'd1,
    MUL_D = 2'd2,
    HOLD  = 2'd3
  } w8_state_e;

  function automatic logic signed [15:0] sat16(input logic signed [16:0] x);
    if (x > 17'sh0_7fff)
      return 16'sh7fff;
    else if (x < 17'sh1_8000)
      return 16'sh8000;
    else
      return x[15:0];
  endfunction

endpackage

// File: rtl/w8_rot_mult.sv
// rtl/w8_rot_mult.sv - combinational sign-magnitude multiply by 1/sqrt(2) in Q12, truncating toward zero
module w8_rot_mult
  import fft_pkg::*;
(
  input  logic signed [15:0] x,
  output logic signed [15:0] y
);

  logic [16:0] mag;
  logic [15:0] mag_m;

  // Sign-magnitude keeps M(-x) = -M(x); 17-bit magnitude lets -32768 map to 32768.
  always_comb begin
    mag   = x[15] ? (17'd0 - {x[15], x}) : {1'b0, x};
    mag_m = 16'((29'(mag) * 29'(HALF_SQRT2_Q12)) >> 12);
    y     = x[15] ? 16'(16'd0 - mag_m) : mag_m;
  end

endmodule

// File: rtl/w8_twiddle_seq.sv
// rtl/w8_twiddle_seq.sv - radix-8 twiddle sequencer (W0/W8^1/W8^2), optional conjugate twiddles via W8_INV_EN
module w8_twiddle_seq
  import fft_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_re,
  input  logic [15:0] in_im,
  input  logic [1:0]  in_tw,
`ifdef W8_INV_EN
  input  logic        in_inv,
`endif
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_re,
  output logic [15:0] out_im
);

  w8_state_e          state;
  logic signed [15:0] s_q;
  logic signed [15:0] d_q;
  logic signed [15:0] mult_in;
  logic signed [15:0] mult_out;
  logic               inv;
  logic               accept;

  logic signed [16:0] sum_ri;
  logic signed [16:0] diff_ir;
  logic signed [16:0] diff_ri;
  logic signed [15:0] neg_re;
  logic signed [15:0] neg_im;
  logic signed [15:0] next_s;
  logic signed [15:0] next_d;
  logic [15:0]        direct_re;
  logic [15:0]        direct_im;

`ifdef W8_INV_EN
  assign inv = in_inv;
`else
  assign inv = 1'b0;
`endif

  assign in_ready = (state == IDLE) || (state == HOLD && out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    sum_ri  = $signed({in_re[15], in_re}) + $signed({in_im[15], in_im});
    diff_ir = $signed({in_im[15], in_im}) - $signed({in_re[15], in_re});
    diff_ri = $signed({in_re[15], in_re}) - $signed({in_im[15], in_im});
    neg_re  = sat16(17'sd0 - $signed({in_re[15], in_re}));
    neg_im  = sat16(17'sd0 - $signed({in_im[15], in_im}));
    next_s  = inv ? sat16(diff_ri) : sat16(sum_ri);
    next_d  = inv ? sat16(sum_ri)  : sat16(diff_ir);
    direct_re = in_re;
    direct_im = in_im;
    if (in_tw == TW_W8_2) begin
      if (inv) begin
        direct_re = neg_im;
        direct_im = in_re;
      end else begin
        direct_re = in_im;
        direct_im = neg_re;
      end
    end
  end

  // Multiplier input is parked at zero outside the two multiply cycles.
  always_comb begin
    case (state)
      MUL_S:   mult_in = s_q;
      MUL_D:   mult_in = d_q;
      default: mult_in = 16'sd0;
    endcase
  end

  w8_rot_mult u_mult (
    .x (mult_in),
    .y (mult_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_re    <= 16'd0;
      out_im    <= 16'd0;
      s_q       <= 16'sd0;
      d_q       <= 16'sd0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if (accept) begin
            if (in_tw == TW_W8_1) begin
              s_q       <= next_s;
              d_q       <= next_d;
              out_valid <= 1'b0;
              state     <= MUL_S;
            end else begin
              out_re    <= direct_re;
              out_im    <= direct_im;
              out_valid <= 1'b1;
              state     <= HOLD;
            end
          end else if (state == HOLD && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        MUL_S: begin
          out_re <= mult_out;
          state  <= MUL_D;
        end
        MUL_D: begin
          out_im    <= mult_out;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_w8_twiddle_seq.sv
// tb/tb_w8_twiddle_seq.sv - self-checking bench for w8_twiddle_seq against an arithmetic reference model
module tb_w8_twiddle_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_re;
  logic [15:0] in_im;
  logic [1:0]  in_tw;
  logic        in_inv;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_re;
  logic [15:0] out_im;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  w8_twiddle_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .in_tw     (in_tw),
`ifdef W8_INV_EN
    .in_inv    (in_inv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im)
  );

  function automatic int sat(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic int m_ref(input int x);
    int mag;
    int r;
    mag = (x < 0) ? -x : x;
    r   = (mag * 2896) / 4096;
    return (x < 0) ? -r : r;
  endfunction

  function automatic void model(input int re, input int im, input logic [1:0] tw, input bit inv,
                                output int ore, output int oim);
    if (tw == 2'd1) begin
      if (!inv) begin ore = m_ref(sat(re + im)); oim = m_ref(sat(im - re)); end
      else      begin ore = m_ref(sat(re - im)); oim = m_ref(sat(re + im)); end
    end else if (tw == 2'd2) begin
      if (!inv) begin ore = im;        oim = sat(-re); end
      else      begin ore = sat(-im);  oim = re;       end
    end else begin
      ore = re;
      oim = im;
    end
  endfunction

  task automatic drive(input logic [15:0] re, input logic [15:0] im, input logic [1:0] tw, input bit inv);
    in_re    = re;
    in_im    = im;
    in_tw    = tw;
    in_inv   = inv;
    in_valid = 1'b1;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_re = '0; in_im = '0; in_tw = '0; in_inv = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_re !== 16'd0) begin n_err++; $display("FAIL reset_out_re got %h want 0000", out_re); end
    n_cmp++; if (out_im !== 16'd0) begin n_err++; $display("FAIL reset_out_im got %h want 0000", out_im); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_w0;
    drive(16'h1234, 16'hABCD, 2'd0, 1'b0);
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL w0_in_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL w0_out_valid got %b want 1", out_valid); end
    n_cmp++; if ({out_re, out_im} !== 32'h1234ABCD) begin n_err++; $display("FAIL w0_data got %h%h want 1234abcd", out_re, out_im); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL w0_one_cycle got %b want 0", out_valid); end
  endtask

  task automatic test_w8_1;
    drive(16'd16384, 16'd0, 2'd1, 1'b0);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL w8_1_busy_ready[%0d] got %b want 0", k, in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL w8_1_busy_valid[%0d] got %b want 0", k, out_valid); end
      tick();
    end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL w8_1_valid_t3 got %b want 1", out_valid); end
    n_cmp++; if ($signed(out_re) !== 11584) begin n_err++; $display("FAIL w8_1_re got %0d want 11584", $signed(out_re)); end
    n_cmp++; if ($signed(out_im) !== -11584) begin n_err++; $display("FAIL w8_1_im got %0d want -11584", $signed(out_im)); end
    tick();
  endtask

  task automatic test_saturation;
    drive(16'h7fff, 16'h7fff, 2'd1, 1'b0);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    n_cmp++; if (out_valid !== 1'b1 || $signed(out_re) !== 23167 || $signed(out_im) !== 0) begin
      n_err++; $display("FAIL sat_w8_1 got v=%b (%0d,%0d) want v=1 (23167,0)", out_valid, $signed(out_re), $signed(out_im));
    end
    tick();
    drive(16'h8000, 16'd5, 2'd2, 1'b0);
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || $signed(out_re) !== 5 || $signed(out_im) !== 32767) begin
      n_err++; $display("FAIL sat_w8_2 got v=%b (%0d,%0d) want v=1 (5,32767)", out_valid, $signed(out_re), $signed(out_im));
    end
    tick();
  endtask

  task automatic test_backpressure;
    int ere, eim;
    model(32'sh2000, 32'sh1000, 2'd1, 1'b0, ere, eim);
    out_ready = 1'b0;
    drive(16'h2000, 16'h1000, 2'd1, 1'b0);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (out_valid !== 1'b1 || $signed(out_re) !== ere || $signed(out_im) !== eim) begin
        n_err++; $display("FAIL bp_hold[%0d] got v=%b (%0d,%0d) want v=1 (%0d,%0d)", k, out_valid, $signed(out_re), $signed(out_im), ere, eim);
      end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d] got %b want 0", k, in_ready); end
      tick();
    end
    drive(16'h0111, 16'h0222, 2'd0, 1'b0);
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || {out_re, out_im} !== 32'h01110222) begin
      n_err++; $display("FAIL bp_next_sample got v=%b %h%h want v=1 01110222", out_valid, out_re, out_im);
    end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b1;
    drive(16'h3000, 16'h1000, 2'd1, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_idle got %b want 1", in_ready); end
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_spurious[%0d] got %b want 0", k, out_valid); end
    end
  endtask

  task automatic test_back_to_back;
    int pre, pim, ere, eim, accepts;
    logic [15:0] r, i;
    logic [1:0] tw;
    out_ready = 1'b1;
    ere = 0; eim = 0;
    for (int k = 0; k < 8; k++) begin
      r = 16'($urandom); i = 16'($urandom); tw = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd2;
      drive(r, i, tw, 1'b0);
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d] got %b want 1", k, in_ready); end
      if (k > 0) begin
        n_cmp++; if (out_valid !== 1'b1 || $signed(out_re) !== ere || $signed(out_im) !== eim) begin
          n_err++; $display("FAIL b2b_data[%0d] got v=%b (%0d,%0d) want (%0d,%0d)", k, out_valid, $signed(out_re), $signed(out_im), ere, eim);
        end
      end
      pre = $signed(r); pim = $signed(i);
      model(pre, pim, tw, 1'b0, ere, eim);
      tick();
    end
    n_cmp++; if (out_valid !== 1'b1 || $signed(out_re) !== ere || $signed(out_im) !== eim) begin
      n_err++; $display("FAIL b2b_last got v=%b (%0d,%0d) want (%0d,%0d)", out_valid, $signed(out_re), $signed(out_im), ere, eim);
    end
    accepts = 0;
    drive(16'h0100, 16'h0200, 2'd1, 1'b0);
    for (int k = 0; k < 12; k++) begin
      #1;
      if (in_valid && in_ready) accepts++;
      tick();
    end
    in_valid = 1'b0;
    n_cmp++; if (accepts !== 4) begin n_err++; $display("FAIL w8_1_throughput got %0d want 4", accepts); end
    repeat (4) tick();
  endtask

`ifdef W8_INV_EN
  task automatic test_inv;
    out_ready = 1'b1;
    drive(16'd16384, 16'd0, 2'd1, 1'b1);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    n_cmp++; if (out_valid !== 1'b1 || $signed(out_re) !== 11584 || $signed(out_im) !== 11584) begin
      n_err++; $display("FAIL inv_w8_1 got v=%b (%0d,%0d) want (11584,11584)", out_valid, $signed(out_re), $signed(out_im));
    end
    tick();
    drive(16'd3, 16'd7, 2'd2, 1'b1);
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || $signed(out_re) !== -7 || $signed(out_im) !== 3) begin
      n_err++; $display("FAIL inv_w8_2 got v=%b (%0d,%0d) want (-7,3)", out_valid, $signed(out_re), $signed(out_im));
    end
    tick();
  endtask
`endif

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7fff;
      2:       return 16'hffff;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic test_random;
    int exp_re[$];
    int exp_im[$];
    int ere, eim, n_in, drain;
    bit fired, prev_hold, inv;
    logic [15:0] prev_re, prev_im;
    n_in = 0; fired = 1'b0; prev_hold = 1'b0;
    prev_re = '0; prev_im = '0;
    in_valid = 1'b0;
    for (int cyc = 0; cyc < 700; cyc++) begin
      if (fired) in_valid = 1'b0;
      if (prev_hold) begin
        n_cmp++; if (out_valid !== 1'b1 || out_re !== prev_re || out_im !== prev_im) begin
          n_err++; $display("FAIL rnd_stable cyc=%0d got v=%b %h/%h want v=1 %h/%h", cyc, out_valid, out_re, out_im, prev_re, prev_im);
        end
      end
      if (!in_valid && n_in < 160 && $urandom_range(0, 3) != 0) begin
`ifdef W8_INV_EN
        inv = 1'($urandom_range(0, 1));
`else
        inv = 1'b0;
`endif
        drive(pick16(), pick16(), 2'($urandom_range(0, 3)), inv);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      fired = in_valid && in_ready;
      if (fired) begin
        model($signed(in_re), $signed(in_im), in_tw, in_inv, ere, eim);
        exp_re.push_back(ere);
        exp_im.push_back(eim);
        n_in++;
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_re.size() == 0) begin
          n_err++; $display("FAIL rnd_unexpected cyc=%0d got (%0d,%0d) want no output", cyc, $signed(out_re), $signed(out_im));
        end else begin
          ere = exp_re.pop_front();
          eim = exp_im.pop_front();
          if ($signed(out_re) !== ere || $signed(out_im) !== eim) begin
            n_err++; $display("FAIL rnd_data cyc=%0d got (%0d,%0d) want (%0d,%0d)", cyc, $signed(out_re), $signed(out_im), ere, eim);
          end
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_re = out_re; prev_im = out_im;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain = 0;
    while (exp_re.size() > 0 && drain < 40) begin
      #1;
      if (out_valid) begin
        ere = exp_re.pop_front();
        eim = exp_im.pop_front();
        n_cmp++; if ($signed(out_re) !== ere || $signed(out_im) !== eim) begin
          n_err++; $display("FAIL rnd_drain got (%0d,%0d) want (%0d,%0d)", $signed(out_re), $signed(out_im), ere, eim);
        end
      end
      tick();
      drain++;
    end
    n_cmp++; if (exp_re.size() !== 0) begin n_err++; $display("FAIL rnd_leftover got %0d outstanding want 0", exp_re.size()); end
    n_cmp++; if (n_in < 50) begin n_err++; $display("FAIL rnd_accepted got %0d samples want >= 50", n_in); end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_w0();
    test_w8_1();
    test_saturation();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef W8_INV_EN
    test_inv();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
